// File: rtl/data_ram_resp.sv
// Data-memory responder for the MEM stage: wait-stated RAM with byte-lane writes and stall request.
// Optional alignment checking is enabled by defining DRAM_ALIGN_CHK_EN.
module data_ram_resp #(
  parameter int DEPTH_LOG2  = 17,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stallreq_o,
  output logic        align_err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t                state;
  logic [3:0]            cnt;
  logic                  we_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [1:0]            off_q;
  logic [3:0]            sel_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rdata;
  logic                  err_q;
  logic                  commit;
  logic                  legal;
  logic                  addr_unused;

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Upper address bits only select aliases of the same word.
  assign addr_unused = ^{addr_i[31:DEPTH_LOG2+2], off_q};

`ifdef DRAM_ALIGN_CHK_EN
  function automatic logic lane_legal(input logic [3:0] s, input logic [1:0] o);
    case (s)
      4'b1111, 4'b1100, 4'b1000: return (o == 2'b00);
      4'b0100:                   return (o == 2'b01);
      4'b0011, 4'b0010:          return (o == 2'b10);
      4'b0001:                   return (o == 2'b11);
      4'b0000:                   return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction
  assign legal = lane_legal(sel_q, off_q);
`else
  assign legal = 1'b1;
`endif

  assign commit      = (state == BUSY) && ce_i && (cnt == 4'd0);
  assign stallreq_o  = ce_i && (state != DONE);
  assign data_o      = rdata;
  assign align_err_o = err_q;

  always_ff @(posedge clk) begin
    if (state == IDLE && ce_i) begin
      we_q    <= we_i;
      idx_q   <= addr_i[DEPTH_LOG2+1:2];
      off_q   <= addr_i[1:0];
      sel_q   <= sel_i;
      wdata_q <= data_i;
    end
  end

  // sel_q[3] is byte offset 0, which is the most significant lane.
  always_ff @(posedge clk) begin
    if (commit && we_q && legal) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rdata <= 32'd0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          err_q <= 1'b0;
          if (ce_i) begin
            cnt   <= CNT_INIT;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!ce_i) begin
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rdata <= (we_q || !legal) ? 32'd0 : mem[idx_q];
            err_q <= !legal;
            state <= DONE;
          end
        end
        DONE: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_resp.sv
// Scoreboard bench for data_ram_resp: default instance plus a small-depth, 3-wait-state instance.
module tb_data_ram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce0, ce1, we;
  logic [31:0] addr, din;
  logic [3:0]  sel;
  logic [31:0] dout0, dout1;
  logic        st0, st1, ae0, ae1;

  int errors = 0;
  int checks = 0;

  logic [31:0] m0 [int];
  logic [31:0] m1 [int];
  logic [31:0] exp_data_q [$];
  logic        exp_err_q [$];

  always #5 clk = ~clk;

  data_ram_resp u0 (
    .clk(clk), .rst(rst), .ce_i(ce0), .we_i(we), .addr_i(addr), .sel_i(sel), .data_i(din),
    .data_o(dout0), .stallreq_o(st0), .align_err_o(ae0)
  );

  data_ram_resp #(.DEPTH_LOG2(4), .WAIT_CYCLES(3)) u1 (
    .clk(clk), .rst(rst), .ce_i(ce1), .we_i(we), .addr_i(addr), .sel_i(sel), .data_i(din),
    .data_o(dout1), .stallreq_o(st1), .align_err_o(ae1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic legal_pair(input logic [3:0] s, input logic [1:0] o);
    case (s)
      4'b1111, 4'b1100, 4'b1000: return (o == 2'b00);
      4'b0100:                   return (o == 2'b01);
      4'b0011, 4'b0010:          return (o == 2'b10);
      4'b0001:                   return (o == 2'b11);
      4'b0000:                   return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  task automatic access(input int u, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d, input string tag);
    int n, wi;
    logic ok;
    logic [31:0] old, e, got_d;
    ok = 1'b1;
`ifdef DRAM_ALIGN_CHK_EN
    ok = legal_pair(s, a[1:0]);
`endif
    wi = (u == 0) ? int'(a[18:2]) : int'(a[5:2]);
    if (u == 0) old = m0.exists(wi) ? m0[wi] : 32'd0;
    else        old = m1.exists(wi) ? m1[wi] : 32'd0;
    if (w && ok) begin
      e = old;
      for (int b = 0; b < 4; b++) if (s[b]) e[b*8 +: 8] = d[b*8 +: 8];
      if (u == 0) m0[wi] = e; else m1[wi] = e;
    end
    exp_data_q.push_back((w || !ok) ? 32'd0 : old);
    exp_err_q.push_back(!ok);

    @(negedge clk);
    we = w; addr = a; sel = s; din = d;
    if (u == 0) ce0 = 1'b1; else ce1 = 1'b1;
    n = 0;
    #1;
    while (((u == 0) ? st0 : st1) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_stall"}, n, (u == 0) ? 2 : 4);
    got_d = exp_data_q.pop_front();
    check({tag, "_data"}, (u == 0) ? dout0 : dout1, got_d);
    check({tag, "_aerr"}, (u == 0) ? ae0 : ae1, {31'd0, exp_err_q.pop_front()});
    ce0 = 1'b0; ce1 = 1'b0;
    @(negedge clk);
    #1;
    check({tag, "_hold"}, (u == 0) ? dout0 : dout1, got_d);
    check({tag, "_aerr_clr"}, (u == 0) ? ae0 : ae1, 32'd0);
  endtask

  initial begin
    logic [31:0] rv [6];
    logic [3:0]  rs [6];
    rst = 1'b0; ce0 = 1'b0; ce1 = 1'b0; we = 1'b0; addr = '0; din = '0; sel = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_data0", dout0, 32'd0);
    check("rst_data1", dout1, 32'd0);
    check("rst_stall", {30'd0, st0, st1}, 32'd0);
    check("rst_aerr", {30'd0, ae0, ae1}, 32'd0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("idle_stall", {30'd0, st0, st1}, 32'd0);
    end

    access(0, 1'b1, 32'h100, 4'b1111, 32'h12345678, "wr100");
    access(0, 1'b0, 32'h100, 4'b1111, 32'h0, "rd100");

    access(0, 1'b1, 32'h200, 4'b1111, 32'hAABBCCDD, "wr200");
    access(0, 1'b1, 32'h203, 4'b0001, 32'h00000011, "wr203");
    access(0, 1'b0, 32'h200, 4'b0011, 32'h0, "rd200");
    access(0, 1'b1, 32'h200, 4'b0000, 32'hFFFFFFFF, "wr200_nosel");
    access(0, 1'b0, 32'h200, 4'b1111, 32'h0, "rd200b");

    access(0, 1'b1, 32'h300, 4'b1111, 32'h0, "wr300");
    @(negedge clk);
    we = 1'b1; addr = 32'h300; sel = 4'b1111; din = 32'hFFFFFFFF; ce0 = 1'b1;
    #1;
    check("flush_stall_on", st0, 32'd1);
    @(negedge clk);
    ce0 = 1'b0;
    #1;
    check("flush_stall_off", st0, 32'd0);
    access(0, 1'b0, 32'h300, 4'b1111, 32'h0, "rd300");

    access(1, 1'b1, 32'h40, 4'b1111, 32'hCAFEBABE, "wr40");
    access(1, 1'b0, 32'h00, 4'b1111, 32'h0, "rd00");

    access(0, 1'b1, 32'h400, 4'b1111, 32'h12345678, "wr400");
    access(0, 1'b1, 32'h401, 4'b1100, 32'hAABBCCDD, "wr401");
    access(0, 1'b0, 32'h400, 4'b1111, 32'h0, "rd400");

    access(1, 1'b1, 32'h8, 4'b1111, 32'h11111111, "wr8");
    access(1, 1'b0, 32'h8, 4'b1111, 32'h0, "rd8");
    @(negedge clk);
    we = 1'b1; addr = 32'h8; sel = 4'b1111; din = 32'h22222222; ce1 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_data0", dout0, 32'd0);
    check("midrst_data1", dout1, 32'd0);
    check("midrst_stall", st1, 32'd1);
    ce1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    access(1, 1'b0, 32'h8, 4'b1111, 32'h0, "rd8_after_rst");

    for (int i = 0; i < 6; i++) begin
      rv[i] = $urandom;
      rs[i] = 4'($urandom_range(0, 15));
      access(0, 1'b1, 32'h1000 + 32'(i*4), 4'b1111, 32'h5A5A5A5A, "rnd_init");
      access(0, 1'b1, 32'h1000 + 32'(i*4), rs[i], rv[i], "rnd_wr");
    end
    for (int i = 0; i < 6; i++) access(0, 1'b0, 32'h1000 + 32'(i*4), 4'b1111, 32'h0, "rnd_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
